// File: rtl/sb_tx_arbiter.sv
// Purpose : round-robin arbiter sharing the sideband transaction generator
//           between the control-FSM select (req0) and the register-response path (req1).
// Latency : grant/ready, grant_id, busy and trans_sel appear one cycle after a valid in IDLE;
//           the earliest next grant is three cycles after trans_sent.
// Backpressure: a requester holds valid/sel until its one-cycle ready pulse; nothing is
//           granted while a transaction is in flight, during the GAP cycle, or while
//           disconnect_sbtx is high.
//
// Optional feature: define SB_ARB_TIMEOUT_EN to build the WAIT_SENT timeout counter and
// timeout_err. Without it, WAIT_SENT only exits on trans_sent or disconnect_sbtx.
//
// Ports:
//   sb_clk            sideband clock (only clock)
//   rst               synchronous active-low reset
//   req0_valid/sel    control-FSM request and code; req0_ready = accept pulse
//   req1_valid/sel    register-response request and code; req1_ready = accept pulse
//   disconnect_sbtx   TX disconnected: abandon the in-flight transaction, hold off grants
//   trans_sent        generator completion pulse (only honoured in WAIT_SENT)
//   trans_sel         code to the generator, a one-cycle pulse, otherwise 0
//   grant_id          requester owning the current or last transaction
//   busy              high whenever the arbiter is not IDLE
//   timeout_err       one-cycle pulse when WAIT_SENT is aborted by the timeout
module sb_tx_arbiter #(
    parameter int SEL_W          = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             sb_clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [SEL_W-1:0] req0_sel,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             req1_ready,
    input  logic             disconnect_sbtx,
    input  logic             trans_sent,
    output logic [SEL_W-1:0] trans_sel,
    output logic             grant_id,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_SENT = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_nxt;
    logic             last_grant;
    logic             last_grant_nxt;
    logic             grant_id_q;
    logic             grant_id_nxt;
    logic             req0_ready_q;
    logic             req1_ready_q;
    logic             req0_ready_nxt;
    logic             req1_ready_nxt;

    // Requester selection: on a tie the one that did not win last time gets it.
    logic             any_req;
    logic             pick1;
    logic [SEL_W-1:0] pick_sel;
    logic             wait_expired;

    assign any_req  = req0_valid | req1_valid;
    assign pick1    = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign pick_sel = pick1 ? req1_sel : req0_sel;

`ifdef SB_ARB_TIMEOUT_EN
    // Counter value k means k full WAIT_SENT cycles have already elapsed, so
    // reaching TIMEOUT_CYCLES-1 aborts on the TIMEOUT_CYCLES-th waiting cycle.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
    logic             timeout_nxt;

    always_ff @(posedge sb_clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            // ISSUE is the only way into WAIT_SENT, so clear here.
            wait_cnt <= '0;
        end else if ((state == ST_WAIT_SENT) && (wait_cnt != {CNT_W{1'b1}})) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign wait_expired = (state == ST_WAIT_SENT) && (wait_cnt == CNT_LAST);

    // Completion in the same cycle wins over the timeout, and a disconnect
    // abandons the transaction silently.
    assign timeout_nxt = wait_expired && !trans_sent && !disconnect_sbtx;

    always_ff @(posedge sb_clk) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_nxt;
        end
    end

    assign timeout_err = timeout_q;
`else
    // No abort path in this build. The parameter is still referenced so both
    // builds present the same parameter list; the term is constant false.
    assign wait_expired = (TIMEOUT_CYCLES < 0);
    assign timeout_err  = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge sb_clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            sel_q        <= '0;
            last_grant   <= 1'b1;   // req0 wins the first tie
            grant_id_q   <= 1'b0;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            sel_q        <= sel_nxt;
            last_grant   <= last_grant_nxt;
            grant_id_q   <= grant_id_nxt;
            req0_ready_q <= req0_ready_nxt;
            req1_ready_q <= req1_ready_nxt;
        end
    end

    // Next-state and grant decision.
    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel_q;
        last_grant_nxt = last_grant;
        grant_id_nxt   = grant_id_q;
        req0_ready_nxt = 1'b0;
        req1_ready_nxt = 1'b0;

        if (disconnect_sbtx) begin
            // Flush: drop whatever is in flight, keep the round-robin pointer.
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        req0_ready_nxt = ~pick1;
                        req1_ready_nxt = pick1;
                        grant_id_nxt   = pick1;
                        last_grant_nxt = pick1;
                        sel_nxt        = pick_sel;
                        // A zero code is consumed without touching the generator.
                        if (pick_sel != '0) begin
                            state_nxt = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // trans_sent here is ignored: the generator cannot finish in 0 cycles.
                    state_nxt = ST_WAIT_SENT;
                end
                ST_WAIT_SENT: begin
                    if (trans_sent || wait_expired) begin
                        state_nxt = ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // trans_sel is a one-cycle pulse tied to ISSUE; a disconnect in that cycle suppresses it.
    assign trans_sel  = ((state == ST_ISSUE) && !disconnect_sbtx) ? sel_q : '0;
    assign busy       = (state != ST_IDLE);
    assign grant_id   = grant_id_q;
    assign req0_ready = req0_ready_q;
    assign req1_ready = req1_ready_q;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Purpose : self-checking bench for sb_tx_arbiter: directed scenarios with literal
//           expectations plus randomized traffic checked every cycle against a
//           transaction-level model.
// Latency/backpressure: requesters hold valid/sel until their ready pulse.
module tb_sb_tx_arbiter;

    localparam int SEL_W = 3;
    localparam int TO    = 16;

    logic             sb_clk = 1'b0;
    logic             rst;
    logic             req0_valid;
    logic [SEL_W-1:0] req0_sel;
    logic             req0_ready;
    logic             req1_valid;
    logic [SEL_W-1:0] req1_sel;
    logic             req1_ready;
    logic             disconnect_sbtx;
    logic             trans_sent;
    logic [SEL_W-1:0] trans_sel;
    logic             grant_id;
    logic             busy;
    logic             timeout_err;

    always #5 sb_clk = ~sb_clk;

    sb_tx_arbiter #(
        .SEL_W          (SEL_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sb_clk          (sb_clk),
        .rst             (rst),
        .req0_valid      (req0_valid),
        .req0_sel        (req0_sel),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_sel        (req1_sel),
        .req1_ready      (req1_ready),
        .disconnect_sbtx (disconnect_sbtx),
        .trans_sent      (trans_sent),
        .trans_sel       (trans_sel),
        .grant_id        (grant_id),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model. Phase of the current transaction and how many
    // waiting cycles have elapsed; expected outputs for the cycle after each edge.
    // ------------------------------------------------------------------
    localparam int P_IDLE = 0;
    localparam int P_ISSUE = 1;
    localparam int P_WAIT = 2;
    localparam int P_GAP = 3;

    int m_phase  = P_IDLE;
    int m_waited = 0;
    int m_sel    = 0;
    bit m_last   = 1'b1;
    bit m_gid    = 1'b0;
    bit e_r0     = 1'b0;
    bit e_r1     = 1'b0;
    bit e_to     = 1'b0;
    bit chk_en   = 1'b0;

    task automatic model_step();
        bit who;
        int s;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        e_to = 1'b0;
        if (!rst) begin
            m_phase = P_IDLE;
            m_last  = 1'b1;
            m_gid   = 1'b0;
            m_sel   = 0;
        end else if (disconnect_sbtx) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        who = (req0_valid && req1_valid) ? !m_last : req1_valid;
                        s   = who ? int'(req1_sel) : int'(req0_sel);
                        e_r0   = !who;
                        e_r1   = who;
                        m_gid  = who;
                        m_last = who;
                        if (s != 0) begin
                            m_sel   = s;
                            m_phase = P_ISSUE;
                        end
                    end
                end
                P_ISSUE: begin
                    m_phase  = P_WAIT;
                    m_waited = 0;
                end
                P_WAIT: begin
                    m_waited++;
                    if (trans_sent) m_phase = P_GAP;
`ifdef SB_ARB_TIMEOUT_EN
                    else if (m_waited == TO) begin
                        e_to    = 1'b1;
                        m_phase = P_GAP;
                    end
`endif
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    // Per-cycle comparison, half a cycle away from the active edge.
    always @(negedge sb_clk) begin
        if (chk_en) begin
            check("cyc_trans_sel", int'(trans_sel),
                  (m_phase == P_ISSUE && !disconnect_sbtx) ? m_sel : 0);
            check("cyc_busy", int'(busy), int'(m_phase != P_IDLE));
            check("cyc_grant_id", int'(grant_id), int'(m_gid));
            check("cyc_req0_ready", int'(req0_ready), int'(e_r0));
            check("cyc_req1_ready", int'(req1_ready), int'(e_r1));
            check("cyc_timeout_err", int'(timeout_err), int'(e_to));
        end
    end

    task automatic tick();
        @(posedge sb_clk);
        model_step();
        #1;
    endtask

    task automatic wait_ready(input string name, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            seen = req0_ready | req1_ready;
        end
        check({name, "_ready_seen"}, int'(seen), 1);
    endtask

    int t5_at;

    initial begin
        rst             = 1'b0;
        req0_valid      = 1'b0;
        req0_sel        = '0;
        req1_valid      = 1'b0;
        req1_sel        = '0;
        disconnect_sbtx = 1'b0;
        trans_sent      = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_trans_sel", int'(trans_sel), 0);
        check("rst_timeout_err", int'(timeout_err), 0);

        // Single request, sel=2, completion 10 cycles later.
        rst = 1'b1; req0_valid = 1'b1; req0_sel = 3'd2;
        tick();
        check("t1_req0_ready", int'(req0_ready), 1);
        check("t1_trans_sel", int'(trans_sel), 2);
        check("t1_busy", int'(busy), 1);
        req0_valid = 1'b0;
        tick();
        check("t1_sel_one_cycle", int'(trans_sel), 0);
        repeat (9) tick();
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        check("t1_gap_busy", int'(busy), 1);
        tick();
        check("t1_idle_busy", int'(busy), 0);

        // Both requesters held from reset: alternate 0,1,0,1 with codes 1,4,1,4.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req0_valid = 1'b1; req0_sel = 3'd1;
        req1_valid = 1'b1; req1_sel = 3'd4;
        for (int k = 0; k < 4; k++) begin
            wait_ready("t2", 8);
            check("t2_grant_id", int'(grant_id), k % 2);
            check("t2_trans_sel", int'(trans_sel), (k % 2 == 1) ? 4 : 1);
            tick();
            trans_sent = 1'b1;
            tick();
            trans_sent = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Zero code: consumed, generator untouched.
        req1_valid = 1'b1; req1_sel = 3'd0;
        wait_ready("t3", 4);
        check("t3_req1_ready", int'(req1_ready), 1);
        check("t3_trans_sel", int'(trans_sel), 0);
        check("t3_busy", int'(busy), 0);
        req1_valid = 1'b0;
        tick();
        check("t3_busy_after", int'(busy), 0);

        // Disconnect during WAIT_SENT, with a pending req0 held across it.
        req0_valid = 1'b1; req0_sel = 3'd5;
        wait_ready("t4", 4);
        req0_valid = 1'b0;
        tick();
        tick();
        disconnect_sbtx = 1'b1;
        req0_valid = 1'b1; req0_sel = 3'd3;
        tick();
        check("t4_busy", int'(busy), 0);
        check("t4_timeout_err", int'(timeout_err), 0);
        repeat (5) begin
            tick();
            check("t4_no_grant", int'(req0_ready), 0);
        end
        disconnect_sbtx = 1'b0;
        tick();
        check("t4_release_grant", int'(req0_ready), 1);
        check("t4_release_sel", int'(trans_sel), 3);
        req0_valid = 1'b0;
        tick();
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        tick();

        // Generator never answers.
        req1_valid = 1'b1; req1_sel = 3'd6;
        wait_ready("t5", 4);
        req1_valid = 1'b0;
        tick();                         // first WAIT_SENT cycle
`ifdef SB_ARB_TIMEOUT_EN
        t5_at = -1;
        for (int i = 1; i <= TO + 4 && t5_at < 0; i++) begin
            tick();
            if (timeout_err) t5_at = i;
        end
        check("t5_timeout_delay", t5_at, TO);
        check("t5_gap_busy", int'(busy), 1);
        tick();
        check("t5_idle_busy", int'(busy), 0);
`else
        t5_at = 0;
        for (int i = 1; i <= TO + 20; i++) begin
            tick();
            if (timeout_err) t5_at++;
        end
        check("t5_still_busy", int'(busy), 1);
        check("t5_no_timeout", t5_at, 0);
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        tick();
        check("t5_done_busy", int'(busy), 0);
`endif
        disconnect_sbtx = 1'b1;
        tick();
        disconnect_sbtx = 1'b0;

        // trans_sent in IDLE and in ISSUE is ignored.
        trans_sent = 1'b1;
        tick();
        check("t6_idle_busy", int'(busy), 0);
        req0_valid = 1'b1; req0_sel = 3'd7;
        tick();
        check("t6_issue_sel", int'(trans_sel), 7);
        req0_valid = 1'b0;
        tick();
        trans_sent = 1'b0;
        check("t6_wait_busy", int'(busy), 1);
        tick();
        check("t6_still_wait", int'(busy), 1);
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        tick();
        tick();

        // Randomized traffic; the per-cycle compare does the checking.
        for (int c = 0; c < 4000; c++) begin
            if (!req0_valid || req0_ready) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_sel   = 3'($urandom_range(0, 7));
            end
            if (!req1_valid || req1_ready) begin
                req1_valid = ($urandom_range(0, 1) != 0);
                req1_sel   = 3'($urandom_range(0, 7));
            end
            trans_sent      = ($urandom_range(0, 4) == 0);
            disconnect_sbtx = ($urandom_range(0, 29) == 0);
            rst             = ($urandom_range(0, 399) != 0);
            tick();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
